// File: rtl/dds_mod_ctrl_pkg.sv
// Shared types for the DDS config sequencer: FSM states, modulation encodings
// and the config payload carried from the request port to the shadow/output regs.
package dds_ctrl_pkg;

    localparam int unsigned PHASE_W = 32;
    localparam int unsigned SEL_W   = 8;
    localparam int unsigned MOD_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        PENDING,
        COMMIT,
        SETTLE,
        RUN
    } state_t;

    localparam logic [MOD_W-1:0] MOD_ASK  = 4'd0;
    localparam logic [MOD_W-1:0] MOD_FSK  = 4'd1;
    localparam logic [MOD_W-1:0] MOD_BPSK = 4'd2;
    localparam logic [MOD_W-1:0] MOD_LFSR = 4'd3;

    typedef struct packed {
        logic [PHASE_W-1:0] phase_inc;
        logic [PHASE_W-1:0] fsk_inc;
        logic [SEL_W-1:0]   sig_sel;
        logic [MOD_W-1:0]   mod_sel;
    } cfg_t;

endpackage

// File: rtl/dds_mod_ctrl_if.sv
// Config request channel (valid/ready plus tone/modulation payload) between
// the user-control decode logic and the DDS config sequencer.
interface dds_mod_ctrl_if;
    import dds_ctrl_pkg::*;

    logic               cfg_valid;
    logic               cfg_ready;
    logic [PHASE_W-1:0] cfg_phase_inc;
    logic [PHASE_W-1:0] cfg_fsk_inc;
    logic [SEL_W-1:0]   cfg_sig_sel;
    logic [MOD_W-1:0]   cfg_mod_sel;

    modport master (
        output cfg_valid,
        output cfg_phase_inc,
        output cfg_fsk_inc,
        output cfg_sig_sel,
        output cfg_mod_sel,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_phase_inc,
        input  cfg_fsk_inc,
        input  cfg_sig_sel,
        input  cfg_mod_sel,
        output cfg_ready
    );

endinterface

// File: rtl/dds_mod_ctrl_lfsr_edge_det.sv
// Symbol boundary detector: rising edge of the (already synced) LFSR bit,
// as a same-cycle strobe for the sequencer and a registered one-cycle tick.
module lfsr_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic lfsr_bit,
    output logic sym_edge_c,
    output logic sym_tick
);

    logic lfsr_q;

    assign sym_edge_c = lfsr_bit & ~lfsr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q   <= 1'b0;
            sym_tick <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_bit;
            sym_tick <= sym_edge_c;
        end
    end

endmodule

// File: rtl/dds_mod_ctrl.sv
// DDS config sequencer: shadows config requests and commits them only on a
// symbol boundary, then freezes the accumulator briefly. Optional PENDING
// timeout is enabled with the DDS_CTRL_TIMEOUT_EN macro.
module dds_mod_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
`ifdef DDS_CTRL_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 50000,
`endif
    parameter int unsigned CNT_W          = 16
) (
    input  logic               clk,
    input  logic               reset,
    dds_mod_ctrl_if.slave      cfg,
    input  logic               lfsr_bit,
    output logic               en,
    output logic [PHASE_W-1:0] phase_inc,
    output logic [PHASE_W-1:0] fsk_phase_inc,
    output logic [SEL_W-1:0]   sig_sel,
    output logic [MOD_W-1:0]   mod_sel,
    output logic               lfsr,
    output logic               sym_tick,
    output logic [CNT_W-1:0]   sym_count
);

    localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam int unsigned SET_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;

    state_t           state_q, state_d;
    cfg_t             shadow_q, shadow_d, out_q, out_d, req;
    logic             en_q, en_d, ready_q, ready_d, lfsr_q, lfsr_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             transfer, sym_edge;

`ifdef DDS_CTRL_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0]  timeout_q, timeout_d;
`endif

    lfsr_edge_det u_edge (
        .clk        (clk),
        .reset      (reset),
        .lfsr_bit   (lfsr_bit),
        .sym_edge_c (sym_edge),
        .sym_tick   (sym_tick)
    );

    assign transfer = cfg.cfg_valid && ready_q;
    assign req      = '{phase_inc: cfg.cfg_phase_inc, fsk_inc: cfg.cfg_fsk_inc,
                        sig_sel: cfg.cfg_sig_sel, mod_sel: cfg.cfg_mod_sel};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            out_q     <= '0;
            en_q      <= 1'b0;
            ready_q   <= 1'b1;
            lfsr_q    <= 1'b0;
            settle_q  <= '0;
            count_q   <= '0;
`ifdef DDS_CTRL_TIMEOUT_EN
            timeout_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            out_q     <= out_d;
            en_q      <= en_d;
            ready_q   <= ready_d;
            lfsr_q    <= lfsr_d;
            settle_q  <= settle_d;
            count_q   <= count_d;
`ifdef DDS_CTRL_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        shadow_d  = transfer ? req : shadow_q;
        out_d     = out_q;
        settle_d  = settle_q;
        count_d   = count_q;
`ifdef DDS_CTRL_TIMEOUT_EN
        timeout_d = transfer ? '0 : timeout_q;
`endif

        // Symbols are only counted while a committed config is live.
        if ((state_q == RUN || state_q == PENDING) && sym_tick && count_q != '1) begin
            count_d = count_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (transfer) state_d = PENDING;
            end
            PENDING: begin
                // A request landing on the boundary wins; the commit waits for the next edge.
                if (!transfer) begin
                    if (sym_edge) begin
                        state_d = COMMIT;
                    end
`ifdef DDS_CTRL_TIMEOUT_EN
                    else if (timeout_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d = COMMIT;
                    end else begin
                        timeout_d = timeout_q + TO_W'(1);
                    end
`endif
                end
            end
            COMMIT: begin
                if (settle_q == '0) begin
                    state_d = RUN;
                end else begin
                    state_d  = SETTLE;
                    settle_d = settle_q - SET_W'(1);
                end
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    state_d = RUN;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            RUN: begin
                if (transfer) state_d = PENDING;
            end
            default: state_d = IDLE;
        endcase

        // Output regs load as COMMIT is entered so they appear with sym_tick.
        if (state_d == COMMIT) begin
            out_d    = shadow_q;
            count_d  = '0;
            settle_d = SET_W'(SETTLE_EFF - 1);
        end

        en_d    = (state_d == RUN) || (state_d == PENDING && en_q);
        ready_d = (state_d == IDLE) || (state_d == PENDING) || (state_d == RUN);
        lfsr_d  = lfsr_bit & en_d;
    end

    assign cfg.cfg_ready  = ready_q;
    assign en             = en_q;
    assign phase_inc      = out_q.phase_inc;
    assign fsk_phase_inc  = out_q.fsk_inc;
    assign sig_sel        = out_q.sig_sel;
    assign mod_sel        = out_q.mod_sel;
    assign lfsr           = lfsr_q;
    assign sym_count      = count_q;

endmodule

// File: tb/tb_dds_mod_ctrl.sv
// Bench for dds_mod_ctrl: scoreboard of expected committed configs, one task per scenario.
module tb_dds_mod_ctrl;
    import dds_ctrl_pkg::*;

    localparam int unsigned CNT_W = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               lfsr_bit;
    logic               en;
    logic [PHASE_W-1:0] phase_inc;
    logic [PHASE_W-1:0] fsk_phase_inc;
    logic [SEL_W-1:0]   sig_sel;
    logic [MOD_W-1:0]   mod_sel;
    logic               lfsr;
    logic               sym_tick;
    logic [CNT_W-1:0]   sym_count;

    dds_mod_ctrl_if cif ();

    dds_mod_ctrl #(
        .SETTLE_CYCLES  (4),
`ifdef DDS_CTRL_TIMEOUT_EN
        .TIMEOUT_CYCLES (20),
`endif
        .CNT_W          (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg           (cif),
        .lfsr_bit      (lfsr_bit),
        .en            (en),
        .phase_inc     (phase_inc),
        .fsk_phase_inc (fsk_phase_inc),
        .sig_sel       (sig_sel),
        .mod_sel       (mod_sel),
        .lfsr          (lfsr),
        .sym_tick      (sym_tick),
        .sym_count     (sym_count)
    );

    always #5 clk = ~clk;

    int   n_pass  = 0;
    int   n_total = 0;
    cfg_t exp_q[$];
    cfg_t cur = '0;
    cfg_t exp_c;
    cfg_t got;
    logic tog_en = 1'b0;
    int   ph = 0;
    logic seen_516 = 1'b0;

    always @(negedge clk) if (phase_inc == 32'd516) seen_516 <= 1'b1;

    always_comb got = '{phase_inc: phase_inc, fsk_inc: fsk_phase_inc, sig_sel: sig_sel, mod_sel: mod_sel};

    function automatic cfg_t mk(input logic [31:0] p, input logic [31:0] f,
                                input logic [7:0] s, input logic [3:0] m);
        return '{phase_inc: p, fsk_inc: f, sig_sel: s, mod_sel: m};
    endfunction

    function automatic cfg_t pop_exp();
        cfg_t c;
        if (exp_q.size() == 0) return '1;
        c = exp_q.pop_front();
        return c;
    endfunction

    // One clock; outputs are stable on return, then the optional LFSR pattern advances.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (tog_en) begin
            ph++;
            if (ph == 3) begin
                ph = 0;
                lfsr_bit = ~lfsr_bit;
            end
        end
    endtask

    // Drive one request; last request before a commit replaces the pending expectation.
    task automatic send(input cfg_t c);
        for (int k = 0; k < 50 && !cif.cfg_ready; k++) cyc();
        cif.cfg_valid     = 1'b1;
        cif.cfg_phase_inc = c.phase_inc;
        cif.cfg_fsk_inc   = c.fsk_inc;
        cif.cfg_sig_sel   = c.sig_sel;
        cif.cfg_mod_sel   = c.mod_sel;
        cyc();
        cif.cfg_valid = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        exp_q.push_back(c);
    endtask

    task automatic wait_en(input string name, input int want);
        int n = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (en === 1'b1) begin n = i; break; end
        end
        n_total++;
        if (n !== want) $display("FAIL %s en rise latency: got %0d expected %0d", name, n, want);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        lfsr_bit = 1'b0;
        cif.cfg_valid = 1'b0;
        cif.cfg_phase_inc = '0;
        cif.cfg_fsk_inc = '0;
        cif.cfg_sig_sel = '0;
        cif.cfg_mod_sel = '0;
        repeat (3) cyc();
        n_total++; if (en !== 1'b0) $display("FAIL reset en: got %b expected 0", en); else n_pass++;
        n_total++; if (got !== '0) $display("FAIL reset cfg outputs: got %h expected 0", got); else n_pass++;
        n_total++; if (cif.cfg_ready !== 1'b1) $display("FAIL reset cfg_ready: got %b expected 1", cif.cfg_ready); else n_pass++;
        n_total++; if (sym_count !== '0) $display("FAIL reset sym_count: got %0d expected 0", sym_count); else n_pass++;
        n_total++; if ({lfsr, sym_tick} !== 2'b00) $display("FAIL reset lfsr/sym_tick: got %b expected 00", {lfsr, sym_tick}); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_first_commit();
        logic early_ok = 1'b1;
        logic low_ok = 1'b1;
        send(mk(32'd258, 32'd86, 8'h01, MOD_FSK));
        tog_en = 1'b1;
        ph = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (phase_inc !== '0) early_ok = 1'b0;
        end
        n_total++; if (!early_ok) $display("FAIL first early commit: got phase_inc %0d expected 0", phase_inc); else n_pass++;
        cyc();
        exp_c = pop_exp();
        n_total++; if (got !== exp_c) $display("FAIL first commit payload: got %h expected %h", got, exp_c); else n_pass++;
        cur = exp_c;
        n_total++; if ({sym_tick, en, lfsr} !== 3'b100) $display("FAIL first commit tick/en/lfsr: got %b expected 100", {sym_tick, en, lfsr}); else n_pass++;
        n_total++; if (cif.cfg_ready !== 1'b0) $display("FAIL first commit cfg_ready: got %b expected 0", cif.cfg_ready); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (en !== 1'b0) low_ok = 1'b0;
        end
        n_total++; if (!low_ok) $display("FAIL first settle en: got %b expected 0", en); else n_pass++;
        cyc();
        n_total++; if ({en, cif.cfg_ready} !== 2'b11) $display("FAIL first run en/ready: got %b expected 11", {en, cif.cfg_ready}); else n_pass++;
    endtask

    task automatic test_last_wins();
        tog_en = 1'b0;
        lfsr_bit = 1'b0;
        cyc();
        send(mk(32'd516, 32'd1, 8'h02, MOD_ASK));
        send(mk(32'd774, 32'd2, 8'h03, MOD_BPSK));
        n_total++; if ({en, phase_inc} !== {1'b1, cur.phase_inc}) $display("FAIL last-wins pending: got en %b phase %0d expected en 1 phase %0d", en, phase_inc, cur.phase_inc); else n_pass++;
        lfsr_bit = 1'b1;
        cyc();
        exp_c = pop_exp();
        n_total++; if (got !== exp_c) $display("FAIL last-wins payload: got %h expected %h", got, exp_c); else n_pass++;
        cur = exp_c;
        wait_en("last-wins", 4);
        n_total++; if (seen_516 !== 1'b0) $display("FAIL last-wins stale 516 seen: got %b expected 0", seen_516); else n_pass++;
    endtask

    task automatic test_edge_collision();
        cfg_t c2;
        lfsr_bit = 1'b0;
        cyc();
        send(mk(32'd1000, 32'd3, 8'h04, MOD_LFSR));
        c2 = mk(32'd1100, 32'd4, 8'h05, MOD_FSK);
        lfsr_bit = 1'b1;
        cif.cfg_valid = 1'b1;
        cif.cfg_phase_inc = c2.phase_inc;
        cif.cfg_fsk_inc = c2.fsk_inc;
        cif.cfg_sig_sel = c2.sig_sel;
        cif.cfg_mod_sel = c2.mod_sel;
        cyc();
        cif.cfg_valid = 1'b0;
        void'(exp_q.pop_back());
        exp_q.push_back(c2);
        n_total++; if ({sym_tick, cif.cfg_ready, phase_inc} !== {2'b11, cur.phase_inc}) $display("FAIL collision no commit: got tick %b ready %b phase %0d expected 1 1 %0d", sym_tick, cif.cfg_ready, phase_inc, cur.phase_inc); else n_pass++;
        lfsr_bit = 1'b0;
        cyc();
        cyc();
        n_total++; if (phase_inc !== cur.phase_inc) $display("FAIL collision hold: got %0d expected %0d", phase_inc, cur.phase_inc); else n_pass++;
        lfsr_bit = 1'b1;
        cyc();
        exp_c = pop_exp();
        n_total++; if (got !== exp_c) $display("FAIL collision next-edge payload: got %h expected %h", got, exp_c); else n_pass++;
        cur = exp_c;
        wait_en("collision", 4);
    endtask

    task automatic test_sym_count();
        lfsr_bit = 1'b0;
        tog_en = 1'b1;
        ph = 0;
        repeat (30) cyc();
        n_total++; if (sym_count !== 4'd5) $display("FAIL sym_count after 5 edges: got %0d expected 5", sym_count); else n_pass++;
        repeat (94) cyc();
        n_total++; if (sym_count !== 4'd15) $display("FAIL sym_count saturate: got %0d expected 15", sym_count); else n_pass++;
        tog_en = 1'b0;
        lfsr_bit = 1'b0;
        send(mk(32'd1300, 32'd5, 8'h06, MOD_ASK));
        n_total++; if (sym_count !== 4'd15) $display("FAIL sym_count pending: got %0d expected 15", sym_count); else n_pass++;
        lfsr_bit = 1'b1;
        cyc();
        exp_c = pop_exp();
        n_total++; if ({got, sym_count} !== {exp_c, 4'd0}) $display("FAIL sym_count commit clear: got %h/%0d expected %h/0", got, sym_count, exp_c); else n_pass++;
        cur = exp_c;
        wait_en("sym_count", 4);
    endtask

    task automatic test_timeout_and_reset();
        int n = 0;
        lfsr_bit = 1'b0;
        cyc();
        send(mk(32'd2000, 32'd6, 8'h07, MOD_BPSK));
`ifdef DDS_CTRL_TIMEOUT_EN
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (phase_inc !== cur.phase_inc) begin n = i; break; end
        end
        n_total++; if (n !== 20) $display("FAIL timeout commit cycle: got %0d expected 20", n); else n_pass++;
`else
        for (int i = 1; i <= 1000; i++) begin
            cyc();
            if (phase_inc !== cur.phase_inc && n == 0) n = i;
        end
        n_total++; if (n !== 0) $display("FAIL no-timeout hold: changed at cycle %0d expected never", n); else n_pass++;
        lfsr_bit = 1'b1;
        cyc();
`endif
        exp_c = pop_exp();
        n_total++; if (got !== exp_c) $display("FAIL timeout payload: got %h expected %h", got, exp_c); else n_pass++;
        cur = exp_c;
        cyc();
        n_total++; if ({en, cif.cfg_ready} !== 2'b00) $display("FAIL mid-settle state: got en/ready %b expected 00", {en, cif.cfg_ready}); else n_pass++;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        exp_q.delete();
        cur = '0;
        n_total++; if ({got, en, cif.cfg_ready, sym_count, lfsr} !== {cfg_t'('0), 1'b0, 1'b1, 4'd0, 1'b0}) $display("FAIL settle reset values: got %h en %b ready %b cnt %0d lfsr %b expected 0 0 1 0 0", got, en, cif.cfg_ready, sym_count, lfsr); else n_pass++;
        lfsr_bit = 1'b0;
        cyc();
        lfsr_bit = 1'b1;
        cyc();
        cyc();
        n_total++; if ({got, en} !== {cfg_t'('0), 1'b0}) $display("FAIL shadow discarded: got %h en %b expected 0 0", got, en); else n_pass++;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_commit();
        test_last_wins();
        test_edge_collision();
        test_sym_count();
        test_timeout_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
